register_file: RTL and testbench

//  Architectural register file with per-register rename tags for the Tomasulo core.

---
 rtl/register_file_pkg.sv | 10 +
 rtl/register_file_read_port.sv | 39 +++
 rtl/register_file.sv | 119 +++++++++++
 tb/tb_register_file.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared sizing constants for the architectural register file and its read ports.
// The ROB tag width must track the 16-entry reorder buffer.
package register_file_pkg;

    localparam int REG_NUM_DEF = 32;
    localparam int XLEN_DEF    = 32;
    localparam int ENTRY_W_DEF = 4;
    localparam int RD_W        = 6;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational operand lookup: stored value/busy/tag, with a same-cycle commit bypass.
// x0 always reads as zero and never busy.
module regfile_read_port
    import register_file_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int XLEN    = XLEN_DEF,
    parameter int ENTRY_W = ENTRY_W_DEF,
    parameter int IDX_W   = $clog2(REG_NUM)
) (
    input  logic [IDX_W-1:0]                idx_i,
    input  logic [REG_NUM-1:0][XLEN-1:0]    val_i,
    input  logic [REG_NUM-1:0]              busy_i,
    input  logic [REG_NUM-1:0][ENTRY_W-1:0] tag_i,
    input  logic                            commitEn_i,
    input  logic [ENTRY_W-1:0]              commitEntry_i,
    input  logic [XLEN-1:0]                 commitResult_i,
    output logic [XLEN-1:0]                 val_o,
    output logic                            busy_o,
    output logic [ENTRY_W-1:0]              tag_o
);

    always_comb begin
        val_o  = '0;
        busy_o = 1'b0;
        tag_o  = '0;
        if (idx_i != '0) begin
            val_o  = val_i[idx_i];
            busy_o = busy_i[idx_i];
            tag_o  = tag_i[idx_i];
            // The producer is retiring right now, so hand its result straight to the consumer.
            if (commitEn_i && busy_i[idx_i] && (tag_i[idx_i] == commitEntry_i)) begin
                val_o  = commitResult_i;
                busy_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register ROB rename tags for the Tomasulo core.
// Issue renames rd, ROB commit retires results, roll_back clears every pending rename.
module register_file
    import register_file_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int XLEN    = XLEN_DEF,
    parameter int ENTRY_W = ENTRY_W_DEF,
    parameter int IDX_W   = $clog2(REG_NUM)
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    input  logic               roll_back,
    input  logic               issue_valid,
    input  logic [RD_W-1:0]    issue_rd,
    input  logic [ENTRY_W-1:0] issue_entry,
    input  logic [IDX_W-1:0]   rs1_idx,
    input  logic [IDX_W-1:0]   rs2_idx,
    output logic [XLEN-1:0]    rs1_val,
    output logic [XLEN-1:0]    rs2_val,
    output logic               rs1_busy,
    output logic               rs2_busy,
    output logic [ENTRY_W-1:0] rs1_tag,
    output logic [ENTRY_W-1:0] rs2_tag,
    input  logic               rob_commit,
    input  logic [RD_W-1:0]    rob_des_commit,
    input  logic [ENTRY_W-1:0] rob_entry_commit,
    input  logic [XLEN-1:0]    rob_result_out
);

    logic [REG_NUM-1:0][XLEN-1:0]    val_q, val_d;
    logic [REG_NUM-1:0]              busy_q, busy_d;
    logic [REG_NUM-1:0][ENTRY_W-1:0] tag_q, tag_d;

    logic [IDX_W-1:0] issueRd;
    logic [IDX_W-1:0] commitRd;
    logic             commitEn;
    logic             issueEn;
    logic             unusedRdBits;

    // Register indices arrive 6 bits wide; only the low bits address the file.
    assign issueRd      = issue_rd[IDX_W-1:0];
    assign commitRd     = rob_des_commit[IDX_W-1:0];
    assign unusedRdBits = issue_rd[RD_W-1] ^ rob_des_commit[RD_W-1];

    assign commitEn = rob_commit && rdy_in;
    assign issueEn  = issue_valid && rdy_in && !roll_back && (issueRd != '0);

    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (commitEn && (commitRd != '0)) begin
            val_d[commitRd] = rob_result_out;
            // Only the newest renamer of rd may clear busy; an older commit leaves it pending.
            if (tag_q[commitRd] == rob_entry_commit) begin
                busy_d[commitRd] = 1'b0;
            end
        end
        if (rdy_in && roll_back) begin
            for (int i = 0; i < REG_NUM; i++) begin
                busy_d[i] = 1'b0;
            end
        end else if (issueEn) begin
            busy_d[issueRd] = 1'b1;
            tag_d[issueRd]  = issue_entry;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            val_q  <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    regfile_read_port #(
        .REG_NUM (REG_NUM),
        .XLEN    (XLEN),
        .ENTRY_W (ENTRY_W),
        .IDX_W   (IDX_W)
    ) u_rs1_port (
        .idx_i          (rs1_idx),
        .val_i          (val_q),
        .busy_i         (busy_q),
        .tag_i          (tag_q),
        .commitEn_i     (commitEn),
        .commitEntry_i  (rob_entry_commit),
        .commitResult_i (rob_result_out),
        .val_o          (rs1_val),
        .busy_o         (rs1_busy),
        .tag_o          (rs1_tag)
    );

    regfile_read_port #(
        .REG_NUM (REG_NUM),
        .XLEN    (XLEN),
        .ENTRY_W (ENTRY_W),
        .IDX_W   (IDX_W)
    ) u_rs2_port (
        .idx_i          (rs2_idx),
        .val_i          (val_q),
        .busy_i         (busy_q),
        .tag_i          (tag_q),
        .commitEn_i     (commitEn),
        .commitEntry_i  (rob_entry_commit),
        .commitResult_i (rob_result_out),
        .val_o          (rs2_val),
        .busy_o         (rs2_busy),
        .tag_o          (rs2_tag)
    );

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against an array-based reference model.
module tb_register_file;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        roll_back;
    logic        issue_valid;
    logic [5:0]  issue_rd;
    logic [3:0]  issue_entry;
    logic [4:0]  rs1_idx, rs2_idx;
    logic [31:0] rs1_val, rs2_val;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag;
    logic        rob_commit;
    logic [5:0]  rob_des_commit;
    logic [3:0]  rob_entry_commit;
    logic [31:0] rob_result_out;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: plain arrays updated from the architectural rules.
    logic [31:0] mVal  [32];
    logic        mBusy [32];
    logic [3:0]  mTag  [32];

    register_file dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .rdy_in           (rdy_in),
        .roll_back        (roll_back),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .issue_entry      (issue_entry),
        .rs1_idx          (rs1_idx),
        .rs2_idx          (rs2_idx),
        .rs1_val          (rs1_val),
        .rs2_val          (rs2_val),
        .rs1_busy         (rs1_busy),
        .rs2_busy         (rs2_busy),
        .rs1_tag          (rs1_tag),
        .rs2_tag          (rs2_tag),
        .rob_commit       (rob_commit),
        .rob_des_commit   (rob_des_commit),
        .rob_entry_commit (rob_entry_commit),
        .rob_result_out   (rob_result_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, observed, expected);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            mVal[i]  = '0;
            mBusy[i] = 1'b0;
            mTag[i]  = '0;
        end
    endtask

    // What a lookup must return given the model and the commit bus currently driven.
    task automatic modelLookup(input int idx, output logic [31:0] v, output logic b, output logic [3:0] t);
        v = '0; b = 1'b0; t = '0;
        if (idx != 0) begin
            v = mVal[idx]; b = mBusy[idx]; t = mTag[idx];
            if (rob_commit && rdy_in && mBusy[idx] && mTag[idx] == rob_entry_commit) begin
                v = rob_result_out;
                b = 1'b0;
            end
        end
    endtask

    task automatic modelUpdate(input logic iv, input logic [5:0] ird, input logic [3:0] ie,
                               input logic cv, input logic [5:0] crd, input logic [3:0] ce,
                               input logic [31:0] res, input logic rb, input logic rdy);
        int c, d;
        c = int'(crd[4:0]);
        d = int'(ird[4:0]);
        if (!rdy) return;
        if (cv && c != 0) begin
            mVal[c] = res;
            if (mTag[c] == ce) mBusy[c] = 1'b0;
        end
        if (rb) begin
            for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
        end else if (iv && d != 0) begin
            mBusy[d] = 1'b1;
            mTag[d]  = ie;
        end
    endtask

    task automatic checkLookups();
        logic [31:0] v;
        logic        b;
        logic [3:0]  t;
        modelLookup(int'(rs1_idx), v, b, t);
        checkOutput("rs1_val", rs1_val, v);
        checkOutput("rs1_busy", {31'b0, rs1_busy}, {31'b0, b});
        if (b) checkOutput("rs1_tag", {28'b0, rs1_tag}, {28'b0, t});
        modelLookup(int'(rs2_idx), v, b, t);
        checkOutput("rs2_val", rs2_val, v);
        checkOutput("rs2_busy", {31'b0, rs2_busy}, {31'b0, b});
        if (b) checkOutput("rs2_tag", {28'b0, rs2_tag}, {28'b0, t});
    endtask

    task automatic driveIdle();
        rdy_in      = 1'b1;
        roll_back   = 1'b0;
        issue_valid = 1'b0;
        rob_commit  = 1'b0;
    endtask

    // One clock of activity: drive at negedge, check lookups mid-cycle, then advance the model.
    task automatic applyStimulus(input logic iv, input logic [5:0] ird, input logic [3:0] ie,
                                 input logic cv, input logic [5:0] crd, input logic [3:0] ce,
                                 input logic [31:0] res, input logic rb, input logic rdy,
                                 input logic [4:0] a, input logic [4:0] b);
        @(negedge clk_in);
        issue_valid = iv; issue_rd = ird; issue_entry = ie;
        rob_commit = cv; rob_des_commit = crd; rob_entry_commit = ce; rob_result_out = res;
        roll_back = rb; rdy_in = rdy; rs1_idx = a; rs2_idx = b;
        #1 checkLookups();
        @(posedge clk_in);
        #1 modelUpdate(iv, ird, ie, cv, crd, ce, res, rb, rdy);
        driveIdle();
        #1;
    endtask

    // Directed check of a stored register through port 2 with fixed expected values.
    task automatic checkReg(input string name, input logic [4:0] idx, input logic [31:0] v,
                            input logic b, input logic [3:0] t);
        rs2_idx = idx;
        #1;
        checkOutput({name, "_val"}, rs2_val, v);
        checkOutput({name, "_busy"}, {31'b0, rs2_busy}, {31'b0, b});
        if (b) checkOutput({name, "_tag"}, {28'b0, rs2_tag}, {28'b0, t});
    endtask

    initial begin
        logic [4:0]  r;
        logic [3:0]  ce;
        rst_n_in = 1'b0;
        driveIdle();
        issue_rd = '0; issue_entry = '0; rob_des_commit = '0; rob_entry_commit = '0;
        rob_result_out = '0; rs1_idx = 5'd0; rs2_idx = 5'd0;
        modelReset();
        #2;
        checkReg("reset_x5", 5'd5, 32'h0, 1'b0, 4'h0);
        checkOutput("reset_tag", {28'b0, rs2_tag}, 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        $display("[TB] rename and commit bypass");
        applyStimulus(1, 6'd5, 4'd3, 0, 6'd0, 4'd0, 32'h0, 0, 1, 5'd5, 5'd0);
        checkReg("t2_pend", 5'd5, 32'h0, 1'b1, 4'd3);
        applyStimulus(0, 6'd0, 4'd0, 1, 6'd5, 4'd3, 32'hDEADBEEF, 0, 1, 5'd5, 5'd5);
        checkReg("t2_done", 5'd5, 32'hDEADBEEF, 1'b0, 4'd0);

        $display("[TB] WAW");
        applyStimulus(1, 6'd7, 4'd2, 0, 6'd0, 4'd0, 32'h0, 0, 1, 5'd7, 5'd0);
        applyStimulus(1, 6'd7, 4'd4, 0, 6'd0, 4'd0, 32'h0, 0, 1, 5'd7, 5'd0);
        applyStimulus(0, 6'd0, 4'd0, 1, 6'd7, 4'd2, 32'h11, 0, 1, 5'd7, 5'd7);
        checkReg("t3_old", 5'd7, 32'h11, 1'b1, 4'd4);
        applyStimulus(0, 6'd0, 4'd0, 1, 6'd7, 4'd4, 32'h22, 0, 1, 5'd7, 5'd7);
        checkReg("t3_new", 5'd7, 32'h22, 1'b0, 4'd0);

        $display("[TB] same-cycle issue and commit");
        applyStimulus(1, 6'd9, 4'd6, 1, 6'd9, 4'd1, 32'h99, 0, 1, 5'd9, 5'd0);
        checkReg("t4", 5'd9, 32'h99, 1'b1, 4'd6);

        $display("[TB] roll_back");
        applyStimulus(1, 6'd3, 4'd7, 0, 6'd0, 4'd0, 32'h0, 0, 1, 5'd3, 5'd0);
        applyStimulus(1, 6'd8, 4'd8, 0, 6'd0, 4'd0, 32'h0, 0, 1, 5'd8, 5'd0);
        applyStimulus(1, 6'd12, 4'd9, 0, 6'd0, 4'd0, 32'h0, 0, 1, 5'd12, 5'd3);
        applyStimulus(1, 6'd14, 4'd5, 1, 6'd8, 4'd0, 32'h88, 1, 1, 5'd3, 5'd12);
        checkReg("t5_x3", 5'd3, 32'h0, 1'b0, 4'd0);
        checkReg("t5_x8", 5'd8, 32'h88, 1'b0, 4'd0);
        checkReg("t5_x12", 5'd12, 32'h0, 1'b0, 4'd0);
        checkReg("t5_x14", 5'd14, 32'h0, 1'b0, 4'd0);
        checkReg("t5_x5", 5'd5, 32'hDEADBEEF, 1'b0, 4'd0);

        $display("[TB] x0 and rdy_in low");
        applyStimulus(1, 6'd0, 4'd1, 1, 6'd32, 4'd0, 32'hFFFF, 0, 1, 5'd0, 5'd0);
        checkReg("t6_x0", 5'd0, 32'h0, 1'b0, 4'd0);
        applyStimulus(1, 6'd11, 4'd5, 0, 6'd0, 4'd0, 32'h0, 0, 1, 5'd11, 5'd0);
        applyStimulus(1, 6'd10, 4'd7, 1, 6'd11, 4'd5, 32'h55, 0, 0, 5'd11, 5'd10);
        checkReg("t6_x11", 5'd11, 32'h0, 1'b0 | 1'b1, 4'd5);
        checkReg("t6_x10", 5'd10, 32'h0, 1'b0, 4'd0);
        applyStimulus(0, 6'd0, 4'd0, 0, 6'd0, 4'd0, 32'h0, 1, 0, 5'd11, 5'd0);
        checkReg("t6_rb_off", 5'd11, 32'h0, 1'b1, 4'd5);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            r  = 5'($urandom_range(0, 31));
            ce = 4'($urandom);
            if (mBusy[r] && $urandom_range(0, 9) < 7) ce = mTag[r];
            applyStimulus($urandom_range(0, 9) < 6, 6'($urandom), 4'($urandom),
                          $urandom_range(0, 9) < 6, {1'($urandom), r}, ce, $urandom,
                          $urandom_range(0, 19) == 0, $urandom_range(0, 9) != 0,
                          5'($urandom), ($urandom_range(0, 3) == 0) ? r : 5'($urandom));
        end

        $display("[TB] reset mid-run");
        @(negedge clk_in);
        #1 rst_n_in = 1'b0;
        modelReset();
        checkReg("rst_x5", 5'd5, 32'h0, 1'b0, 4'd0);
        checkReg("rst_x7", 5'd7, 32'h0, 1'b0, 4'd0);
        checkReg("rst_x9", 5'd9, 32'h0, 1'b0, 4'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        applyStimulus(0, 6'd0, 4'd0, 0, 6'd0, 4'd0, 32'h0, 0, 1, 5'd12, 5'd3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
